// File: rtl/qdi_pkg.sv
// qdi_pkg: rail encodings, scheduler states and the round-robin winner search
package qdi_pkg;

   localparam logic [1:0] QDI_NEUTRAL = 2'b00;
   localparam logic [1:0] QDI_ZERO    = 2'b01;
   localparam logic [1:0] QDI_ONE     = 2'b10;
   localparam int         MAX_REQ     = 8;

   typedef enum logic [1:0] {IDLE, SEND, RTZ} state_e;

   // First set bit of req at or after ptr, wrapping modulo n; ptr if none set
   function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr, input int n);
      int   idx;
      logic found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int i = 0; i < MAX_REQ; i++) begin
         idx = (int'(ptr) + i) % n;
         if (!found && i < n && req[idx[2:0]]) begin
            rr_pick = idx[2:0];
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/qdi_enable_sync.sv
// qdi_enable_sync: multi-flop synchronizer for the asynchronous channel enable
module qdi_enable_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] s_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) s_q <= '0;
      else         s_q <= {s_q[STAGES-2:0], d_i};
   end

   assign q_o = s_q[STAGES-1];

endmodule

// File: rtl/qdi_rr_channel_scheduler.sv
// qdi_rr_channel_scheduler: round-robin sharing of one dual-rail channel with four-phase handshake
module qdi_rr_channel_scheduler
   import qdi_pkg::*;
#(
   parameter int N_REQ          = 2,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                       CLK,
   input  logic                       RESET,
   inout  wire                        VDD,
   inout  wire                        GND,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ-1:0]           data,
   output logic [N_REQ-1:0]           ack,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy,
   output logic [1:0]                 Tx,
   input  logic                       Txe,
   output logic                       stall
);

   localparam int            GW   = $clog2(N_REQ);
   localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES);

   state_e            state_q, state_d;
   logic [1:0]        tx_q, tx_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic [GW-1:0]     gid_q, gid_d, ptr_q, ptr_d, win;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              txe_s, grant, done, unused_supply;

   qdi_enable_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (CLK),
      .rst_ni (RESET),
      .d_i    (Txe),
      .q_o    (txe_s)
   );

   assign win           = GW'(rr_pick(MAX_REQ'(req), 3'(ptr_q), N_REQ));
   assign grant         = state_q == IDLE && txe_s && |req;
   assign done          = state_q == SEND && !txe_s;
   assign unused_supply = VDD ^ GND;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= IDLE;
         tx_q    <= QDI_NEUTRAL;
         ack_q   <= '0;
         gid_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         ack_q   <= ack_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      state_d = grant ? SEND : done ? RTZ : (state_q == RTZ && txe_s) ? IDLE : state_q;
   end

   // Rails only leave neutral on a grant and only return on token acceptance
   always_comb begin
      tx_d  = grant ? (data[win] ? QDI_ONE : QDI_ZERO) : done ? QDI_NEUTRAL : tx_q;
      gid_d = grant ? win : gid_q;
      ack_d = done ? N_REQ'(1'b1) << gid_q : '0;
      ptr_d = done ? ((gid_q == GW'(N_REQ - 1)) ? '0 : gid_q + 1'b1) : ptr_q;
      cnt_d = (state_d != state_q) ? '0 : (state_q != IDLE && cnt_q != CMAX) ? cnt_q + 1'b1 : cnt_q;
   end

   assign Tx       = tx_q;
   assign ack      = ack_q;
   assign grant_id = gid_q;
   assign busy     = state_q != IDLE;
   assign stall    = cnt_q == CMAX;

endmodule
